// File: rtl/display_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver: frame-synchronised BCD update,
// anti-ghosting blank interval, leading-zero blanking and whole-display blink.
module display_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] bcd_in,
    input  logic        load,
    input  logic        blank_lead,
    input  logic        blink_en,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  dig_sel_n,
    output logic        frame_done
);
    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [1:0]         r_dig_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [15:0]        r_active;
    logic [15:0]        r_pending;
    logic               r_pending_valid;

    logic       w_slot_wrap;
    logic       w_boundary;
    logic       w_blank3;
    logic       w_blank2;
    logic       w_blank1;
    logic [3:0] w_blank;
    logic [3:0] w_digit;
    logic       w_lit;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b0111111;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    assign w_boundary  = w_slot_wrap && (r_dig_idx == 2'd3);

    // Blanking ripples down from the most significant digit; digit 0 always shows.
    assign w_blank3 = blank_lead && (r_active[15:12] == 4'd0);
    assign w_blank2 = w_blank3 && (r_active[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_active[7:4] == 4'd0);
    assign w_blank  = {w_blank3, w_blank2, w_blank1, 1'b0};

    assign w_digit = r_active[{r_dig_idx, 2'b00} +: 4];
    assign w_lit   = (int'(r_slot_cnt) >= BLANK_CYCLES)
                  && !w_blank[r_dig_idx]
                  && !(blink_en && r_blink_phase);

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= 2'd0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= r_dig_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // A load landing on the boundary bypasses pending so it is not a frame late.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active        <= 16'h0000;
            r_pending       <= 16'h0000;
            r_pending_valid <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_active        <= bcd_in;
                r_pending_valid <= 1'b0;
            end else if (r_pending_valid) begin
                r_active        <= r_pending;
                r_pending_valid <= 1'b0;
            end
        end else if (load) begin
            r_pending       <= bcd_in;
            r_pending_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            dig_sel_n  <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            if (w_lit) begin
                seg_n     <= seg_encode(w_digit);
                dp_n      <= ~dp_mask[r_dig_idx];
                dig_sel_n <= ~(4'b0001 << r_dig_idx);
            end else begin
                seg_n     <= 7'h7F;
                dp_n      <= 1'b1;
                dig_sel_n <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: cycle scoreboard from a reference model plus
// table-driven per-digit frame checks and hand-written boundary/blink/reset sequences.
module tb_display_scan_driver;
    localparam int R  = 8;
    localparam int BC = 2;
    localparam int BD = 64;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic [15:0] bcd_in     = 16'h0000;
    logic        load       = 1'b0;
    logic        blank_lead = 1'b0;
    logic        blink_en   = 1'b0;
    logic [3:0]  dp_mask    = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_sel_n;
    logic        frame_done;

    display_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
        .clock(clock), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .blank_lead(blank_lead), .blink_en(blink_en), .dp_mask(dp_mask),
        .seg_n(seg_n), .dp_n(dp_n), .dig_sel_n(dig_sel_n), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } out_t;

    typedef struct packed {
        logic [15:0]     bcd;
        logic            bl;
        logic [3:0]      dpm;
        logic [3:0][6:0] seg;   // expected per digit, 7F = never lit
    } vec_t;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    localparam logic [12:0] RESET_OUT = 13'h1FFE;

    out_t        sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic        last_fd = 1'b0;
    logic [6:0]  cap_seg [4];
    int          cap_lit [4];
    int          cap_first;

    int          m_slot = 0;
    int          m_dig = 0;
    int          m_bcnt = 0;
    logic        m_phase = 1'b0;
    logic        m_pv = 1'b0;
    logic [15:0] m_active = 16'h0000;
    logic [15:0] m_pend = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic lead_dark(input logic [15:0] v, input int k, input logic en);
        if (!en || k == 0) return 1'b0;
        for (int j = k; j < 4; j++)
            if (v[j*4 +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic out_t model_out(input int slot, input int dig, input logic [15:0] act,
                                       input logic phase, input logic blk, input logic bl,
                                       input logic [3:0] dpm);
        out_t o;
        o.fd = (slot == R - 1) && (dig == 3);
        if (slot < BC || (blk && phase) || lead_dark(act, dig, bl)) begin
            o.seg = 7'h7F;
            o.dp  = 1'b1;
            o.dig = 4'hF;
        end else begin
            o.seg      = SEG_REF[act[dig*4 +: 4]];
            o.dp       = !dpm[dig];
            o.dig      = 4'hF;
            o.dig[dig] = 1'b0;
        end
        return o;
    endfunction

    // Reference model: pushes the output expected after each edge, then advances.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_slot   <= 0;
            m_dig    <= 0;
            m_bcnt   <= 0;
            m_phase  <= 1'b0;
            m_pv     <= 1'b0;
            m_active <= 16'h0000;
            m_pend   <= 16'h0000;
            sb_q.delete();
        end else begin
            sb_q.push_back(model_out(m_slot, m_dig, m_active, m_phase, blink_en, blank_lead, dp_mask));
            if (m_slot == R - 1) begin
                m_slot <= 0;
                m_dig  <= (m_dig + 1) % 4;
            end else begin
                m_slot <= m_slot + 1;
            end
            if (m_slot == R - 1 && m_dig == 3) begin
                if (load) begin
                    m_active <= bcd_in;
                    m_pv     <= 1'b0;
                end else if (m_pv) begin
                    m_active <= m_pend;
                    m_pv     <= 1'b0;
                end
            end else if (load) begin
                m_pend <= bcd_in;
                m_pv   <= 1'b1;
            end
            if (!blink_en) begin
                m_bcnt  <= 0;
                m_phase <= 1'b0;
            end else if (m_bcnt == BD - 1) begin
                m_bcnt  <= 0;
                m_phase <= !m_phase;
            end else begin
                m_bcnt <= m_bcnt + 1;
            end
        end
    end

    task automatic tick();
        out_t e;
        @(negedge clock);
        last_fd = 1'b0;
        if (!reset_n) begin
            check("reset_outputs", {seg_n, dp_n, dig_sel_n, frame_done}, RESET_OUT);
        end else if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got no expected entry at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            last_fd = e.fd;
            check("scan_outputs", {seg_n, dp_n, dig_sel_n, frame_done}, e);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_fd && n < 4 * R + 4);
        if (!last_fd) begin
            n_total++;
            $display("FAIL wait_frame_timeout: got no frame boundary within %0d cycles", n);
        end
    endtask

    task automatic capture_frame();
        cap_first = -1;
        for (int i = 0; i < 4; i++) begin
            cap_seg[i] = 7'h7F;
            cap_lit[i] = 0;
        end
        for (int c = 0; c < 4 * R; c++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if (dig_sel_n[i] == 1'b0) begin
                    cap_seg[i] = seg_n;
                    cap_lit[i]++;
                    if (cap_first < 0) cap_first = i;
                end
        end
    endtask

    task automatic load_value(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before 1000000");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        logic [6:0] d0_seen;
        int   n;

        vecs[0] = '{16'h1234, 1'b0, 4'b0000, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h0007, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}};
        vecs[2] = '{16'h0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
        vecs[3] = '{16'h00A5, 1'b1, 4'b0010, {7'h7F, 7'h7F, 7'b0111111, 7'b0010010}};
        vecs[4] = '{16'h0000, 1'b0, 4'b1000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[5] = '{16'h9068, 1'b1, 4'b0100, {7'b0010000, 7'b1000000, 7'b0000010, 7'b0000000}};
        vecs[6] = '{16'h0F01, 1'b1, 4'b0000, {7'h7F, 7'b0111111, 7'b1000000, 7'b1111001}};

        repeat (3) tick();
        #2 reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            blank_lead = vecs[v].bl;
            dp_mask    = vecs[v].dpm;
            load_value(vecs[v].bcd);
            wait_frame();
            capture_frame();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d_dig%0d_seg", v, i), 32'(cap_seg[i]), 32'(vecs[v].seg[i]));
                check($sformatf("vec%0d_dig%0d_lit_cycles", v, i), cap_lit[i],
                      (vecs[v].seg[i] == 7'h7F) ? 0 : R - BC);
            end
        end

        // Mid-frame load must not disturb the frame in progress.
        blank_lead = 1'b0;
        dp_mask    = 4'h0;
        load_value(16'h1234);
        wait_frame();
        capture_frame();
        blank_lead = 1'b1;
        load_value(16'h0007);
        d0_seen = 7'h7F;
        n = 0;
        while (!last_fd && n < 4 * R + 4) begin
            tick();
            n++;
            if (dig_sel_n == 4'b1110) d0_seen = seg_n;
        end
        check("midframe_old_digit0", 32'(d0_seen), 32'(7'b0011001));
        capture_frame();
        check("midframe_new_digit0", 32'(cap_seg[0]), 32'(7'b1111000));
        check("midframe_upper_dark", cap_lit[1] + cap_lit[2] + cap_lit[3], 0);

        // Loads one cycle before and exactly at the boundary: the boundary one wins.
        blank_lead = 1'b0;
        n = 0;
        while (!(m_slot == R - 2 && m_dig == 3) && n < 4 * R + 4) begin
            tick();
            n++;
        end
        check("boundary_align", m_slot * 4 + m_dig, (R - 2) * 4 + 3);
        bcd_in = 16'h5555;
        load   = 1'b1;
        tick();
        bcd_in = 16'h8888;
        tick();
        load   = 1'b0;
        check("boundary_pending_valid", 32'(dut.r_pending_valid), 32'd0);
        wait_frame();
        capture_frame();
        check("boundary_value_frame1", 32'(cap_seg[0]), 32'(7'b0000000));
        capture_frame();
        check("boundary_value_frame2", 32'(cap_seg[2]), 32'(7'b0000000));

        // Blink: dark during the off phase, scan resumes the cycle after blink_en drops.
        blink_en = 1'b1;
        n = 0;
        while (!(m_phase && m_bcnt == 4) && n < 4 * BD) begin
            tick();
            n++;
        end
        check("blink_off_phase_reached", 32'(m_phase), 32'd1);
        check("blink_dark", 32'(dig_sel_n), 32'hF);
        n = 0;
        while (m_slot < BC && n < R) begin
            tick();
            n++;
        end
        blink_en = 1'b0;
        tick();
        check("blink_resume", 32'(dig_sel_n != 4'hF), 32'd1);
        capture_frame();

        // Asynchronous reset mid-slot, then restart at digit 0 showing 0000.
        tick();
        #2 reset_n = 1'b0;
        #1 check("async_reset_immediate", {seg_n, dp_n, dig_sel_n, frame_done}, RESET_OUT);
        tick();
        tick();
        #2 reset_n = 1'b1;
        blank_lead = 1'b1;
        capture_frame();
        check("restart_first_lit_digit", cap_first, 0);
        check("restart_digit0_seg", 32'(cap_seg[0]), 32'(7'b1000000));
        check("restart_upper_dark", cap_lit[1] + cap_lit[2] + cap_lit[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Downstream consumer of the scoreboard datapath (shot-clock BCD, score BCD).
- Time-multiplexes four packed BCD digits onto one shared 7-segment bus with per-digit enables.
- Features: tear-free frame-boundary update, anti-ghosting blank interval, leading-zero blanking, whole-display blink for buzzer/timeout indication.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digit enables off; range 0 to REFRESH_DIV-1.
- BLINK_DIV, 25000000: cycles per blink half-period.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- bcd_in  in  16  packed BCD; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
- load  in  1  capture bcd_in into the pending register this cycle.
- blank_lead  in  1  enable leading-zero blanking.
- blink_en  in  1  enable whole-display blink.
- dp_mask  in  4  per-digit decimal point, 1 = on.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- dig_sel_n  out  4  digit enables, bit i = digit i, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, reset_n low) sets:
  - seg_n = 7'h7F, dp_n = 1, dig_sel_n = 4'hF, frame_done = 0.
  - active = 0, pending = 0, pending_valid = 0.
  - slot_cnt = 0, dig_idx = 0, blink_cnt = 0, blink_phase = 0.
- Release is asynchronous; the first scan starts at digit 0 with slot_cnt = 0.
- Slot counter:
  - slot_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, dig_idx advances 0→1→2→3→0.
- Frame boundary: the cycle where slot_cnt = REFRESH_DIV-1 and dig_idx = 3.
  - In the following cycle, frame_done = 1 for exactly one cycle.
- Load and pending register:
  - load = 1 writes bcd_in into pending and sets pending_valid.
  - Multiple loads before a boundary: the last one wins.
  - At the boundary, if pending_valid, then active ← pending and pending_valid is cleared.
  - load asserted in the boundary cycle itself: active ← bcd_in directly and pending_valid stays 0.
- Leading-zero blanking, computed from active:
  - Digit 3 is blank if it equals 0.
  - Digit k (k = 2, 1) is blank if digit k+1 is blank and digit k equals 0.
  - Digit 0 is never blanked.
  - Has no effect when blank_lead = 0.
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 show a dash: 0111111.
- Blink:
  - While blink_en = 1, blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles on each wrap.
  - When blink_en = 0, blink_cnt and blink_phase are held at 0. Deasserting blink_en takes effect next cycle.
- Outputs are registered; the value in cycle t+1 is a function of state in cycle t.
- dig_sel_n[dig_idx] = 0 only if all of the following hold:
  - slot_cnt >= BLANK_CYCLES
  - the digit is not blanked
  - not (blink_en and blink_phase)
  - Otherwise dig_sel_n = 4'hF.
- seg_n and dp_n:
  - When dig_sel_n = 4'hF: seg_n = 7'h7F and dp_n = 1.
  - Otherwise seg_n = encoding of active digit dig_idx, and dp_n = ~dp_mask[dig_idx].
- dp_mask is sampled live, not frame-synchronised.

Test Plan:
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64.
- Reset, then load 16'h1234 → after the first frame_done, dig_sel_n cycles 1110,1101,1011,0111, each low for 6 of 8 cycles; seg_n = 0011001 ("4") while digit 0 is enabled, 0110000 ("3") while digit 1 is enabled.
- Load 16'h0007 mid-frame with blank_lead=1 → display is unchanged until frame_done; afterwards only digit 0 is enabled, seg_n=1111000, and digits 1–3 stay high.
- Load 16'h0000 with blank_lead=1 → digit 0 shows 1000000, others blank. Load 16'h00A5 → digit 1 shows dash 0111111.
- Load at the exact boundary cycle, plus a second load one cycle earlier → the boundary value wins, and pending_valid=0 afterwards.
- blink_en=1 → all dig_sel_n=4'hF for 64-cycle windows, alternating with normal scan. Drop blink_en during the off phase → scan resumes the next cycle.
- Assert reset_n low mid-slot → outputs go to their reset values immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 showing 0000 (only digit 0 lit if blank_lead=1).
